mem_req_arbiter: RTL

//  Round-robin arbiter/sequencer feeding the DRAM request queue from N cache-side requesters.

---
 rtl/mem_req_arbiter_pkg.sv | 35 +++
 rtl/mem_req_arbiter_rr_picker.sv | 30 +++
 rtl/mem_req_arbiter.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/mem_req_arbiter_pkg.sv
// Shared op codes, FSM states, header layout and address window for the DRAM request arbiter.
package mem_req_arbiter_pkg;

   localparam int unsigned NUM_REQ_DEF    = 4;
   localparam int unsigned ID_W_DEF       = 4;
   localparam int unsigned ADDR_W_DEF     = 32;
   localparam int unsigned DATA_W_DEF     = 128;
   localparam int unsigned OP_W           = 2;
   localparam int unsigned BEAT_WIDTH     = 32;
   localparam int unsigned CYCLE_NUM_DATA = 4;
   localparam int unsigned REQ_SIZE_DEF   = ID_W_DEF + OP_W + ADDR_W_DEF;

   // Header field offsets inside q_buf_in
   localparam int unsigned HDR_ADDR_LSB = 0;
   localparam int unsigned HDR_OP_LSB   = ADDR_W_DEF;
   localparam int unsigned HDR_ID_LSB   = ADDR_W_DEF + OP_W;

   localparam logic [31:0] BOUNDARY_UP  = 32'h0000_1FFF;
   localparam logic [31:0] BOUNDARY_LOW = 32'h0000_0000;

   typedef enum logic [1:0] {
      OP_RD  = 2'b00,
      OP_WR  = 2'b01,
      OP_PWB = 2'b10,
      OP_ILL = 2'b11
   } op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_HDR  = 2'd1,
      ST_DATA = 2'd2,
      ST_GAP  = 2'd3
   } state_e;

endpackage

// File: rtl/mem_req_arbiter_rr_picker.sv
// Combinational round-robin pick: first valid requester at or after the pointer, wrapping.
module mem_req_arbiter_rr_picker #(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned IDX_W   = 2
) (
   input  logic [NUM_REQ-1:0] i_valid,
   input  logic [IDX_W-1:0]   i_ptr,
   output logic [NUM_REQ-1:0] o_onehot,
   output logic [IDX_W-1:0]   o_idx,
   output logic               o_any
);

   logic [IDX_W-1:0] w_cand;

   always_comb begin
      o_onehot = '0;
      o_idx    = '0;
      o_any    = 1'b0;
      w_cand   = '0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         w_cand = IDX_W'((32'(i_ptr) + k) % NUM_REQ);
         if (!o_any && i_valid[w_cand]) begin
            o_any            = 1'b1;
            o_idx            = w_cand;
            o_onehot[w_cand] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/mem_req_arbiter.sv
// Round-robin arbiter serialising RD (header only) and WR/PWB (header + 4 beats + gap)
// requests onto the DRAM request queue push port.
module mem_req_arbiter
   import mem_req_arbiter_pkg::*;
#(
   parameter int unsigned NUM_REQ      = NUM_REQ_DEF,
   parameter int unsigned ID_WIDTH     = ID_W_DEF,
   parameter int unsigned ADDR_WIDTH   = ADDR_W_DEF,
   parameter int unsigned DATA_WIDTH   = DATA_W_DEF,
   parameter int unsigned REQUEST_SIZE = REQ_SIZE_DEF
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NUM_REQ-1:0]            req_valid,
   input  logic [2*NUM_REQ-1:0]          req_op,
   input  logic [ADDR_WIDTH*NUM_REQ-1:0] req_addr,
   input  logic [DATA_WIDTH*NUM_REQ-1:0] req_data,
   output logic [NUM_REQ-1:0]            gnt,
   output logic [NUM_REQ-1:0]            err,
   input  logic                          q_full,
   output logic                          q_push_en,
   output logic [1:0]                    q_op,
   output logic [REQUEST_SIZE-1:0]       q_buf_in,
   output logic                          busy
);

   localparam int unsigned IDX_W = $clog2(NUM_REQ);

   state_e                  r_state, w_state_nxt;
   logic [2:0]              r_cnt;
   logic [IDX_W-1:0]        r_ptr;
   op_e                     r_op;
   logic [DATA_WIDTH-1:0]   r_data;

   logic [NUM_REQ-1:0]      w_win_oh;
   logic [IDX_W-1:0]        w_win_idx;
   logic                    w_win_any;
   op_e                     w_win_op;
   logic [ADDR_WIDTH-1:0]   w_win_addr;
   logic [DATA_WIDTH-1:0]   w_win_data;
   logic                    w_win_bad;
   logic                    w_pick_slot;
   logic                    w_take;
   logic [REQUEST_SIZE-1:0] w_hdr;
   logic [2:0]              w_beat_sel;
   logic [BEAT_WIDTH-1:0]   w_beat;
   logic [IDX_W-1:0]        w_ptr_nxt;

   logic [NUM_REQ-1:0]      w_gnt_nxt;
   logic [NUM_REQ-1:0]      w_err_nxt;
   logic                    w_push_nxt;
   op_e                     w_op_nxt;
   logic [REQUEST_SIZE-1:0] w_buf_nxt;

   mem_req_arbiter_rr_picker #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_picker (
      .i_valid  (req_valid),
      .i_ptr    (r_ptr),
      .o_onehot (w_win_oh),
      .o_idx    (w_win_idx),
      .o_any    (w_win_any)
   );

   // Arbitration runs in IDLE, in GAP, and in a RD header cycle so RDs can stream every cycle
   assign w_pick_slot = (r_state == ST_IDLE) || (r_state == ST_GAP) ||
                        ((r_state == ST_HDR) && (r_op == OP_RD));
   assign w_take      = w_pick_slot && w_win_any && !q_full;

   assign w_win_op   = op_e'(req_op[2*w_win_idx +: 2]);
   assign w_win_addr = req_addr[ADDR_WIDTH*w_win_idx +: ADDR_WIDTH];
   assign w_win_data = req_data[DATA_WIDTH*w_win_idx +: DATA_WIDTH];
   assign w_win_bad  = (w_win_op == OP_ILL) ||
                       (ADDR_WIDTH'(w_win_addr - ADDR_WIDTH'(BOUNDARY_LOW)) >
                        ADDR_WIDTH'(BOUNDARY_UP - BOUNDARY_LOW));
   assign w_hdr      = REQUEST_SIZE'({ID_WIDTH'(w_win_idx), w_win_op, w_win_addr});
   assign w_ptr_nxt  = (32'(w_win_idx) == NUM_REQ - 1) ? '0 : w_win_idx + IDX_W'(1);

   // Beats go out most-significant word first
   assign w_beat_sel = (r_state == ST_HDR) ? 3'd0 : r_cnt + 3'd1;
   assign w_beat     = BEAT_WIDTH'(r_data >> (BEAT_WIDTH *
                                   (CYCLE_NUM_DATA - 1 - 32'(w_beat_sel))));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_state <= ST_IDLE;
      else      r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE, ST_GAP: w_state_nxt = (w_take && !w_win_bad) ? ST_HDR : ST_IDLE;
         ST_HDR: begin
            if (r_op == OP_RD) w_state_nxt = (w_take && !w_win_bad) ? ST_HDR : ST_IDLE;
            else               w_state_nxt = ST_DATA;
         end
         ST_DATA: begin
            if (r_cnt == 3'(CYCLE_NUM_DATA - 1)) w_state_nxt = ST_GAP;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      w_gnt_nxt  = '0;
      w_err_nxt  = '0;
      w_push_nxt = 1'b0;
      w_op_nxt   = OP_RD;
      w_buf_nxt  = '0;
      case (w_state_nxt)
         ST_HDR: begin
            w_push_nxt = 1'b1;
            w_op_nxt   = w_win_op;
            w_buf_nxt  = w_hdr;
            w_gnt_nxt  = w_win_oh;
         end
         ST_DATA: begin
            w_push_nxt = 1'b1;
            w_op_nxt   = r_op;
            w_buf_nxt  = REQUEST_SIZE'(w_beat);
         end
         default: ;
      endcase
      if (w_take && w_win_bad) w_err_nxt = w_win_oh;
   end

   // Request latch, round-robin pointer and beat counter
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_ptr  <= '0;
         r_op   <= OP_RD;
         r_data <= '0;
         r_cnt  <= '0;
      end else begin
         if (w_take) r_ptr <= w_ptr_nxt;
         if (w_take && !w_win_bad) begin
            r_op   <= w_win_op;
            r_data <= w_win_data;
         end
         r_cnt <= (w_state_nxt == ST_DATA) ? w_beat_sel : 3'd0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         gnt       <= '0;
         err       <= '0;
         q_push_en <= 1'b0;
         q_op      <= OP_RD;
         q_buf_in  <= '0;
         busy      <= 1'b0;
      end else begin
         gnt       <= w_gnt_nxt;
         err       <= w_err_nxt;
         q_push_en <= w_push_nxt;
         q_op      <= w_op_nxt;
         q_buf_in  <= w_buf_nxt;
         busy      <= (w_state_nxt != ST_IDLE);
      end
   end

endmodule
